// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with 2 combinational read ports,
// 2 synchronous write ports (port 1 has priority), optional write-to-read
// bypass, optional hardwired zero register and a per-register busy
// scoreboard for RAW hazard detection at decode.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int DBG_IDX  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic              alloc_stall,
    output logic [DATA_W-1:0] dbg_q
);

    localparam logic [ADDR_W:0] NREG_L = (ADDR_W+1)'(NUM_REGS);
    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic                wq0, wq1, w0_eff, alloc_go;
    logic [NUM_REGS-1:0] w0_dec, w1_dec, al_dec;

    // An address is usable when it maps to a real register that is not the hardwired zero
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREG_L) && !(ZR && (a == '0));
    endfunction

    // Bypass view of a read address: does a qualifying write hit it this cycle
    function automatic logic wr_hit(input logic [ADDR_W-1:0] a);
        return (wq1 && (wa1 == a)) || (wq0 && (wa0 == a));
    endfunction

    assign wq0      = we0 && addr_ok(wa0);
    assign wq1      = we1 && addr_ok(wa1);
    assign w0_eff   = wq0 && !(wq1 && (wa1 == wa0));
    assign alloc_go = alloc_en && addr_ok(alloc_addr) && !alloc_stall;

    // Stall only while the destination still has a producer that is not retiring now
    assign alloc_stall = addr_ok(alloc_addr) && busy[alloc_addr]
                         && !(BP && wr_hit(alloc_addr));

    // One-hot decode of the write and allocate targets
    always_comb begin
        w0_dec = '0;
        w1_dec = '0;
        al_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w1_dec[i] = wq1 && (wa1 == ADDR_W'(i));
            w0_dec[i] = w0_eff && (wa0 == ADDR_W'(i));
            al_dec[i] = alloc_go && (alloc_addr == ADDR_W'(i));
        end
    end

    // Register storage: port 1 wins a same-register collision
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst)
                regs[i] <= '0;
            else if (w1_dec[i])
                regs[i] <= wd1;
            else if (w0_dec[i])
                regs[i] <= wd0;
        end
    end

    // Busy scoreboard: a new allocation outranks a retiring write to the same register
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst)
                busy[i] <= 1'b0;
            else if (al_dec[i])
                busy[i] <= 1'b1;
            else if (w1_dec[i] || w0_dec[i])
                busy[i] <= 1'b0;
        end
    end

    // Read port 1: bypassed write data first, then stored contents
    always_comb begin
        rd1 = '0;
        if (BP && wq1 && (wa1 == ra1))
            rd1 = wd1;
        else if (BP && wq0 && (wa0 == ra1))
            rd1 = wd0;
        else if (addr_ok(ra1))
            rd1 = regs[ra1];
        rbusy1 = addr_ok(ra1) && busy[ra1] && !(BP && wr_hit(ra1));
    end

    // Read port 2: same rules as port 1
    always_comb begin
        rd2 = '0;
        if (BP && wq1 && (wa1 == ra2))
            rd2 = wd1;
        else if (BP && wq0 && (wa0 == ra2))
            rd2 = wd0;
        else if (addr_ok(ra2))
            rd2 = regs[ra2];
        rbusy2 = addr_ok(ra2) && busy[ra2] && !(BP && wr_hit(ra2));
    end

    // Debug tap shows architectural state only, never bypassed
    generate
        if (DBG_IDX < NUM_REGS && !(ZR && DBG_IDX == 0)) begin : g_dbg
            assign dbg_q = regs[DBG_IDX];
        end else begin : g_dbg_zero
            assign dbg_q = '0;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two builds share one stimulus stream
// (build 0: defaults with bypass; build 1: BYPASS=0, NUM_REGS=24).
// A behavioural array model predicts every output each cycle.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa0, wa1, alloc_addr;
    logic [31:0] wd0, wd1;
    logic        we0, we1, alloc_en;

    logic [31:0] rd1_o [2];
    logic [31:0] rd2_o [2];
    logic [31:0] dbg_o [2];
    logic        rb1_o [2];
    logic        rb2_o [2];
    logic        st_o  [2];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state per build
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];
    int          nregs  [2] = '{32, 24};
    bit          byp    [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1), .NUM_REGS(32)) u_byp (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_o[0]), .rd2(rd2_o[0]), .rbusy1(rb1_o[0]), .rbusy2(rb2_o[0]),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_stall(st_o[0]),
        .dbg_q(dbg_o[0]));

    reg_file_mp #(.BYPASS(0), .NUM_REGS(24)) u_nob (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_o[1]), .rd2(rd2_o[1]), .rbusy1(rb1_o[1]), .rbusy2(rb2_o[1]),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_stall(st_o[1]),
        .dbg_q(dbg_o[1]));

    function automatic bit usable(int b, logic [4:0] a);
        return (int'(a) < nregs[b]) && (a != 0);
    endfunction

    function automatic bit hits(int b, logic [4:0] a);
        return (we1 && usable(b, wa1) && wa1 == a) || (we0 && usable(b, wa0) && wa0 == a);
    endfunction

    function automatic logic [31:0] exp_rd(int b, logic [4:0] a);
        if (byp[b] && we1 && usable(b, wa1) && wa1 == a) return wd1;
        if (byp[b] && we0 && usable(b, wa0) && wa0 == a) return wd0;
        if (!usable(b, a)) return 32'h0;
        return m_reg[b][a];
    endfunction

    function automatic bit exp_busy(int b, logic [4:0] a);
        if (!usable(b, a)) return 1'b0;
        if (byp[b] && hits(b, a)) return 1'b0;
        return m_busy[b][a];
    endfunction

    function automatic bit exp_stall(int b);
        return usable(b, alloc_addr) && m_busy[b][alloc_addr] && !(byp[b] && hits(b, alloc_addr));
    endfunction

    task automatic chk(string name, int b, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s build%0d t=%0t actual=%h required=%h", name, b, $time, act, exp);
        end
    endtask

    // Model update at each rising edge, from the inputs presented that cycle
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[b][i]  = 32'h0;
                    m_busy[b][i] = 1'b0;
                end
            end else begin
                bit stall;
                stall = exp_stall(b);
                if (we0 && usable(b, wa0) && !(we1 && usable(b, wa1) && wa1 == wa0)) begin
                    m_reg[b][wa0]  = wd0;
                    m_busy[b][wa0] = 1'b0;
                end
                if (we1 && usable(b, wa1)) begin
                    m_reg[b][wa1]  = wd1;
                    m_busy[b][wa1] = 1'b0;
                end
                if (alloc_en && usable(b, alloc_addr) && !stall)
                    m_busy[b][alloc_addr] = 1'b1;
            end
        end
    end

    // Compare all outputs of both builds against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            for (int b = 0; b < 2; b++) begin
                chk("rd1",    b, rd1_o[b], exp_rd(b, ra1));
                chk("rd2",    b, rd2_o[b], exp_rd(b, ra2));
                chk("rbusy1", b, 32'(rb1_o[b]), 32'(exp_busy(b, ra1)));
                chk("rbusy2", b, 32'(rb2_o[b]), 32'(exp_busy(b, ra2)));
                chk("stall",  b, 32'(st_o[b]), 32'(exp_stall(b)));
                chk("dbg_q",  b, dbg_o[b], m_reg[b][9]);
            end
        end
    end

    task automatic idle();
        rst = 0; we0 = 0; we1 = 0; alloc_en = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        ra1 = 0; ra2 = 0; alloc_addr = 0;
    endtask

    // Advance to the next cycle: edge, then inputs return to idle
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Literal expectation checked at the middle of the current cycle
    task automatic lit(string name, int b, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        chk(name, b, act, exp);
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        idle();
        chk_en = 1'b1;

        // Reset clears stored data and ignores a same-cycle write
        we1 = 1; wa1 = 5; wd1 = 32'hDEADBEEF;
        step();
        rst = 1; we1 = 1; wa1 = 5; wd1 = 32'h1;
        step();
        ra1 = 5; ra2 = 9;
        mid();
        for (int b = 0; b < 2; b++) begin
            lit("rst_rd1", b, rd1_o[b], 32'h0);
            lit("rst_busy", b, 32'(rb1_o[b]), 32'h0);
            lit("rst_dbg", b, dbg_o[b], 32'h0);
        end
        step();

        // Zero register: writes and allocs to x0 have no effect
        we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; alloc_en = 1; alloc_addr = 0; ra1 = 0;
        mid();
        lit("zero_rd_same", 0, rd1_o[0], 32'h0);
        lit("zero_stall", 0, 32'(st_o[0]), 32'h0);
        step();
        ra1 = 0;
        mid();
        lit("zero_rd", 0, rd1_o[0], 32'h0);
        lit("zero_busy", 0, 32'(rb1_o[0]), 32'h0);
        step();

        // Dual-write collision: port 1 wins
        we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra1 = 7;
        mid();
        lit("coll_byp", 0, rd1_o[0], 32'h22);
        lit("coll_nobyp", 1, rd1_o[1], 32'h0);
        step();
        ra1 = 7;
        mid();
        for (int b = 0; b < 2; b++) lit("coll_rd", b, rd1_o[b], 32'h22);
        step();

        // Scoreboard allocate / stall / clear
        alloc_en = 1; alloc_addr = 3;
        step();
        ra1 = 3; alloc_en = 1; alloc_addr = 3;
        mid();
        for (int b = 0; b < 2; b++) begin
            lit("sb_busy", b, 32'(rb1_o[b]), 32'h1);
            lit("sb_stall", b, 32'(st_o[b]), 32'h1);
        end
        step();
        we0 = 1; wa0 = 3; wd0 = 32'h55; ra1 = 3; alloc_addr = 3;
        mid();
        lit("wb_busy_byp", 0, 32'(rb1_o[0]), 32'h0);
        lit("wb_rd_byp", 0, rd1_o[0], 32'h55);
        lit("wb_stall_byp", 0, 32'(st_o[0]), 32'h0);
        lit("wb_busy_nob", 1, 32'(rb1_o[1]), 32'h1);
        lit("wb_stall_nob", 1, 32'(st_o[1]), 32'h1);
        step();
        ra1 = 3;
        mid();
        for (int b = 0; b < 2; b++) begin
            lit("wb_clear", b, 32'(rb1_o[b]), 32'h0);
            lit("wb_rd", b, rd1_o[b], 32'h55);
        end
        step();

        // Alloc and write to the same busy register in one cycle
        alloc_en = 1; alloc_addr = 4;
        step();
        we1 = 1; wa1 = 4; wd1 = 32'h9; alloc_en = 1; alloc_addr = 4;
        step();
        ra1 = 4;
        mid();
        lit("aw_rd", 0, rd1_o[0], 32'h9);
        lit("aw_busy_byp", 0, 32'(rb1_o[0]), 32'h1);
        lit("aw_busy_nob", 1, 32'(rb1_o[1]), 32'h0);
        step();

        // Debug tap lags the write by one cycle; no bypass in build 1
        we0 = 1; wa0 = 9; wd0 = 32'h1234; ra2 = 9;
        mid();
        for (int b = 0; b < 2; b++) lit("dbg_pre", b, dbg_o[b], 32'h0);
        lit("dbg_rd_byp", 0, rd2_o[0], 32'h1234);
        lit("dbg_rd_nob", 1, rd2_o[1], 32'h0);
        step();
        mid();
        for (int b = 0; b < 2; b++) lit("dbg_post", b, dbg_o[b], 32'h1234);
        step();

        // Address beyond NUM_REGS in build 1 is ignored and reads 0
        we0 = 1; wa0 = 30; wd0 = 32'hAB;
        step();
        ra1 = 30;
        mid();
        lit("oob_rd_32", 0, rd1_o[0], 32'hAB);
        lit("oob_rd_24", 1, rd1_o[1], 32'h0);
        step();

        // Randomised traffic, addresses biased toward a small set to force collisions
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 99) == 0);
            we0        = ($urandom_range(0, 1) == 1);
            we1        = ($urandom_range(0, 2) == 0);
            alloc_en   = ($urandom_range(0, 2) != 0);
            wa0        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wa1        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            alloc_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
            ra1        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
            ra2        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
            wd0        = $urandom;
            wd1        = $urandom;
            @(posedge clk);
            #1;
        end
        idle();
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
